// File: rtl/signal_sync_filter_pkg.sv
// signal_sync_pkg: shared constants and helpers for signal_sync_filter.
//   EVENT_CNT_W     - width of the optional accepted-edge counter
//   SYNC_STAGES_MIN - shallowest synchroniser chain allowed
//   clog2()         - ceiling log2 for sizing counters from parameters
package signal_sync_pkg;

  localparam int EVENT_CNT_W     = 16;
  localparam int SYNC_STAGES_MIN = 2;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/signal_sync_filter_ch.sv
// signal_sync_filter_ch: one channel of the level synchroniser/deglitcher.
//   clk_in          - clock, all logic on the rising edge
//   rstn_in         - synchronous active-low reset
//   signal_async_in - asynchronous level input
//   signal_out      - synchronised level, accepted after FILTER_CYCLES stable cycles
//   rise_out        - one-cycle pulse when signal_out goes 0->1
//   fall_out        - one-cycle pulse when signal_out goes 1->0
module signal_sync_filter_ch
  import signal_sync_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_CYCLES = 4,
  parameter logic RESET_VALUE   = 1'b0
) (
  input  logic clk_in,
  input  logic rstn_in,
  input  logic signal_async_in,
  output logic signal_out,
  output logic rise_out,
  output logic fall_out
);

  localparam int CNT_W = clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  generate
    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
      $error("signal_sync_filter_ch: SYNC_STAGES must be >= 2");
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
      $error("signal_sync_filter_ch: FILTER_CYCLES must be >= 1");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   sync_lvl;
  logic [CNT_W-1:0]       cnt_p1;

  // Stage 0: synchroniser chain; only its last flop is consumed downstream.
  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      sync_p0 <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], signal_async_in};
    end
  end

  assign sync_lvl = sync_p0[SYNC_STAGES-1];

  // Stage 1: stability filter. A mismatch must persist for FILTER_CYCLES
  // consecutive cycles; any match in between restarts the count.
  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      signal_out <= RESET_VALUE;
      cnt_p1     <= '0;
      rise_out   <= 1'b0;
      fall_out   <= 1'b0;
    end else begin
      rise_out <= 1'b0;
      fall_out <= 1'b0;
      if (sync_lvl == signal_out) begin
        cnt_p1 <= '0;
      end else if (cnt_p1 == CNT_LAST) begin
        signal_out <= sync_lvl;
        cnt_p1     <= '0;
        rise_out   <= sync_lvl;
        fall_out   <= ~sync_lvl;
      end else begin
        cnt_p1 <= cnt_p1 + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/signal_sync_filter.sv
// signal_sync_filter: NUM_CH-channel level synchroniser with deglitch filter
// and per-channel rise/fall event pulses.
//   clk_in          - clock, all logic on the rising edge
//   rstn_in         - synchronous active-low reset
//   signal_async_in - NUM_CH asynchronous level inputs
//   signal_out      - NUM_CH filtered, synchronised levels
//   rise_out        - per-channel one-cycle 0->1 pulses
//   fall_out        - per-channel one-cycle 1->0 pulses
//   event_clr_in    - clears the event counter     (SYNC_EVENT_CNT_EN only)
//   event_count_out - saturating accepted-edge count (SYNC_EVENT_CNT_EN only)
// Optional feature macro: SYNC_EVENT_CNT_EN adds the event counter ports/logic.
module signal_sync_filter
  import signal_sync_pkg::*;
#(
  parameter int                NUM_CH        = 4,
  parameter int                SYNC_STAGES   = 2,
  parameter int                FILTER_CYCLES = 4,
  parameter logic [NUM_CH-1:0] RESET_VALUE   = {NUM_CH{1'b0}}
) (
  input  logic                   clk_in,
  input  logic                   rstn_in,
  input  logic [NUM_CH-1:0]      signal_async_in,
  output logic [NUM_CH-1:0]      signal_out,
  output logic [NUM_CH-1:0]      rise_out,
  output logic [NUM_CH-1:0]      fall_out
`ifdef SYNC_EVENT_CNT_EN
  ,
  input  logic                   event_clr_in,
  output logic [EVENT_CNT_W-1:0] event_count_out
`endif
);

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      signal_sync_filter_ch #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES),
        .RESET_VALUE  (RESET_VALUE[i])
      ) u_ch (
        .clk_in         (clk_in),
        .rstn_in        (rstn_in),
        .signal_async_in(signal_async_in[i]),
        .signal_out     (signal_out[i]),
        .rise_out       (rise_out[i]),
        .fall_out       (fall_out[i])
      );
    end
  endgenerate

`ifdef SYNC_EVENT_CNT_EN
  function automatic logic [EVENT_CNT_W-1:0] popcount(input logic [NUM_CH-1:0] v);
    logic [EVENT_CNT_W-1:0] n;
    n = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      n = n + EVENT_CNT_W'(v[k]);
    end
    return n;
  endfunction

  function automatic logic [EVENT_CNT_W-1:0] sat_add(input logic [EVENT_CNT_W-1:0] a,
                                                     input logic [EVENT_CNT_W-1:0] b);
    logic [EVENT_CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[EVENT_CNT_W] ? {EVENT_CNT_W{1'b1}} : s[EVENT_CNT_W-1:0];
  endfunction

  // Stage 2: event counter, one cycle behind the pulses; clear wins.
  always_ff @(posedge clk_in) begin
    if (!rstn_in || event_clr_in) begin
      event_count_out <= '0;
    end else begin
      event_count_out <= sat_add(event_count_out, popcount(rise_out | fall_out));
    end
  end
`endif

endmodule

// File: tb/tb_signal_sync_filter.sv
module tb_signal_sync_filter;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] d_in, d_so, d_rise, d_fall;
  logic [3:0] rv_in, rv_so, rv_rise, rv_fall;
`ifdef SYNC_EVENT_CNT_EN
  logic        d_clr, rv_clr, f_clr;
  logic [15:0] d_cnt, rv_cnt, f_cnt;
  logic [3:0]  f_in, f_so, f_rise, f_fall;
`endif

  int checks = 0;
  int errors = 0;
  int n_rise, n_fall;

  always #5 clk = ~clk;

  signal_sync_filter u_dut (
    .clk_in         (clk),
    .rstn_in        (rstn),
    .signal_async_in(d_in),
    .signal_out     (d_so),
    .rise_out       (d_rise),
    .fall_out       (d_fall)
`ifdef SYNC_EVENT_CNT_EN
    ,
    .event_clr_in   (d_clr),
    .event_count_out(d_cnt)
`endif
  );

  signal_sync_filter #(.RESET_VALUE(4'b0101)) u_rv (
    .clk_in         (clk),
    .rstn_in        (rstn),
    .signal_async_in(rv_in),
    .signal_out     (rv_so),
    .rise_out       (rv_rise),
    .fall_out       (rv_fall)
`ifdef SYNC_EVENT_CNT_EN
    ,
    .event_clr_in   (rv_clr),
    .event_count_out(rv_cnt)
`endif
  );

`ifdef SYNC_EVENT_CNT_EN
  signal_sync_filter #(.FILTER_CYCLES(1)) u_fast (
    .clk_in         (clk),
    .rstn_in        (rstn),
    .signal_async_in(f_in),
    .signal_out     (f_so),
    .rise_out       (f_rise),
    .fall_out       (f_fall),
    .event_clr_in   (f_clr),
    .event_count_out(f_cnt)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn  = 1'b0;
    d_in  = 4'b0000;
    rv_in = 4'b0101;
`ifdef SYNC_EVENT_CNT_EN
    d_clr = 1'b0; rv_clr = 1'b0; f_clr = 1'b0; f_in = 4'b0000;
`endif
    tick(); tick();

    // reset state
    chk("rv_reset", {rv_so, rv_rise, rv_fall}, {4'b0101, 8'h00});
    chk("d_reset",  {d_so, d_rise, d_fall}, 32'h0);
`ifdef SYNC_EVENT_CNT_EN
    chk("cnt_reset", d_cnt, 32'h0);
`endif

    // reset release with matching static inputs: quiet for 20 cycles
    rstn = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      chk("rv_static", {rv_so, rv_rise, rv_fall}, {4'b0101, 8'h00});
    end

    // clean step on ch0: output and rise pulse at edge 6 only
    d_in = 4'b0001;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("step_so",   d_so,   (e >= 6) ? 32'h1 : 32'h0);
      chk("step_rise", d_rise, (e == 6) ? 32'h1 : 32'h0);
      chk("step_fall", d_fall, 32'h0);
    end

    // 3-cycle glitch on ch1: rejected
    d_in[1] = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      if (e == 4) d_in[1] = 1'b0;
      tick();
      chk("glitch3", {d_so[1], d_rise[1], d_fall[1]}, 32'h0);
    end

    // 4-cycle high on ch1: exactly one rise, then one fall
    n_rise = 0; n_fall = 0;
    d_in[1] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      if (e == 5) d_in[1] = 1'b0;
      tick();
      n_rise += int'(d_rise[1]);
      n_fall += int'(d_fall[1]);
      if (e == 6) chk("pulse4_at6", d_rise[1], 32'h1);
    end
    chk("pulse4_rises", n_rise, 32'd1);
    chk("pulse4_falls", n_fall, 32'd1);
    chk("pulse4_so_end", d_so[1], 32'h0);

    // all channels low, then all rise together
    d_in = 4'b0000;
    for (int e = 1; e <= 10; e++) tick();
    chk("all_low", d_so, 32'h0);
`ifdef SYNC_EVENT_CNT_EN
    d_clr = 1'b1;
    tick();
    d_clr = 1'b0;
    chk("cnt_clr", d_cnt, 32'h0);
`endif
    d_in = 4'b1111;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk("all_rise", d_rise, (e == 6) ? 32'hF : 32'h0);
      chk("all_excl", d_rise & d_fall, 32'h0);
`ifdef SYNC_EVENT_CNT_EN
      chk("all_cnt", d_cnt, (e == 7) ? 32'd4 : 32'd0);
`endif
    end

    // reset while ch2 of u_rv has a partial count of 2
    rv_in = 4'b0001;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk("pre_rst", {rv_so, rv_fall}, {4'b0101, 4'b0000});
    end
    rstn = 1'b0;
    tick();
    chk("mid_rst", {rv_so, rv_rise, rv_fall}, {4'b0101, 8'h00});
    rstn = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("post_rst_so",   rv_so[2],   (e < 6)  ? 32'h1 : 32'h0);
      chk("post_rst_fall", rv_fall[2], (e == 6) ? 32'h1 : 32'h0);
    end

`ifdef SYNC_EVENT_CNT_EN
    // saturation and clear on the FILTER_CYCLES=1 instance: 4 events/cycle
    f_clr = 1'b1;
    tick();
    f_clr = 1'b0;
    chk("f_clr0", f_cnt, 32'h0);
    for (int n = 1; n <= 16390; n++) begin
      f_in = ~f_in;
      f_clr = (n == 16389);
      tick();
      if (n == 10) begin
        chk("f_cnt10", f_cnt, 32'd28);
        chk("f_excl", f_rise & f_fall, 32'h0);
      end
      if (n == 16386) chk("f_near_sat", f_cnt, 32'hFFFC);
      if (n == 16387) chk("f_sat",      f_cnt, 32'hFFFF);
      if (n == 16388) chk("f_sat_hold", f_cnt, 32'hFFFF);
      if (n == 16389) chk("f_clr_win",  f_cnt, 32'h0);
      if (n == 16390) chk("f_after_clr", f_cnt, 32'd4);
    end
    f_clr = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
